// File: rtl/mag_alarm_fsm.sv
// Debounced hysteretic alarm fed by magnitude-comparator flags.
// Emits rise/fall pulses, a saturating rise counter and a sticky flag error.
module mag_alarm_fsm #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic             agtb,
  input  logic             aeqb,
  input  logic             altb,
  input  logic             clr,
  output logic             alarm,
  output logic             alarm_rise,
  output logic             alarm_fall,
  output logic [CNT_W-1:0] event_cnt,
  output logic             flag_err
);

  localparam int CntBits =
    ($clog2(DEBOUNCE + 1) < 2) ? 2 : $clog2(DEBOUNCE + 1);
  localparam logic [CntBits-1:0] DebLast = CntBits'(DEBOUNCE);
  localparam logic [CntBits-1:0] CntOne  = CntBits'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    ACTIVE,
    DISARMING
  } stateT;

  stateT state;
  logic [CntBits-1:0] cnt;
  logic [CntBits-1:0] cntInc;
  logic oneHot;
  logic illegal;
  logic above;
  logic below;

  assign oneHot  = $onehot({agtb, aeqb, altb});
  assign illegal = valid & ~oneHot;
  assign above   = valid & oneHot & agtb;
  assign below   = valid & oneHot & altb;
  assign cntInc  = cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      alarm      <= 1'b0;
      alarm_rise <= 1'b0;
      alarm_fall <= 1'b0;
      event_cnt  <= '0;
      flag_err   <= 1'b0;
    end else begin
      alarm_rise <= 1'b0;
      alarm_fall <= 1'b0;
      if (illegal) flag_err <= 1'b1;
      unique case (state)
        IDLE: begin
          if (above) begin
            state <= ARMING;
            cnt   <= CntOne;
          end
        end
        ARMING: begin
          if (above) begin
            if (cntInc == DebLast) begin
              state      <= ACTIVE;
              cnt        <= '0;
              alarm      <= 1'b1;
              alarm_rise <= 1'b1;
              if (event_cnt != '1) event_cnt <= event_cnt + 1'b1;
            end else begin
              cnt <= cntInc;
            end
          end else if (below) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        ACTIVE: begin
          if (below) begin
            state <= DISARMING;
            cnt   <= CntOne;
          end
        end
        DISARMING: begin
          if (below) begin
            if (cntInc == DebLast) begin
              state      <= IDLE;
              cnt        <= '0;
              alarm      <= 1'b0;
              alarm_fall <= 1'b1;
            end else begin
              cnt <= cntInc;
            end
          end else if (above) begin
            state <= ACTIVE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
      // clear overrides a coincident rise or illegal sample
      if (clr) begin
        event_cnt <= '0;
        flag_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mag_alarm_fsm.sv
// Scoreboard bench for mag_alarm_fsm, default and CNT_W=2 instances.
module tb_mag_alarm_fsm;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic valid, agtb, aeqb, altb, clr;
  logic alarm, rise, fall, ferr;
  logic [7:0] ev;
  logic alarm2, rise2, fall2, ferr2;
  logic [1:0] ev2;

  int nCmp = 0;
  int nBad = 0;

  typedef struct {
    int alarm;
    int rise;
    int fall;
    int err;
    int ev;
    int ev2;
  } expT;

  expT q[$];

  // reference model state
  int mState = 0;
  int mCnt = 0;
  int mAlarm = 0;
  int mEv = 0;
  int mEv2 = 0;
  int mErr = 0;

  always #5 clk = ~clk;

  mag_alarm_fsm #(.DEBOUNCE(DEB), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid),
    .agtb(agtb), .aeqb(aeqb), .altb(altb), .clr(clr),
    .alarm(alarm), .alarm_rise(rise), .alarm_fall(fall),
    .event_cnt(ev), .flag_err(ferr)
  );

  mag_alarm_fsm #(.DEBOUNCE(DEB), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid(valid),
    .agtb(agtb), .aeqb(aeqb), .altb(altb), .clr(clr),
    .alarm(alarm2), .alarm_rise(rise2), .alarm_fall(fall2),
    .event_cnt(ev2), .flag_err(ferr2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s @%0t: got %0d want %0d", tag, $time, got, exp);
    end
  endtask

  task automatic modelReset();
    mState = 0; mCnt = 0; mAlarm = 0;
    mEv = 0; mEv2 = 0; mErr = 0;
  endtask

  task automatic step(input logic v, input logic a, input logic e,
                      input logic l, input logic c);
    expT x;
    int nf;
    int r, f;
    valid = v; agtb = a; aeqb = e; altb = l; clr = c;
    nf = int'(a) + int'(e) + int'(l);
    r = 0; f = 0;
    if (v && nf != 1) mErr = 1;
    if (v && nf == 1) begin
      case (mState)
        0: if (a) begin mState = 1; mCnt = 1; end
        1: if (a) begin
             if (mCnt + 1 == DEB) begin
               mState = 2; mCnt = 0; mAlarm = 1; r = 1;
             end else mCnt++;
           end else if (l) begin mState = 0; mCnt = 0; end
        2: if (l) begin mState = 3; mCnt = 1; end
        default: if (l) begin
             if (mCnt + 1 == DEB) begin
               mState = 0; mCnt = 0; mAlarm = 0; f = 1;
             end else mCnt++;
           end else if (a) begin mState = 2; mCnt = 0; end
      endcase
    end
    if (r == 1) begin
      if (mEv < 255) mEv++;
      if (mEv2 < 3) mEv2++;
    end
    if (c) begin mEv = 0; mEv2 = 0; mErr = 0; end
    x.alarm = mAlarm; x.rise = r; x.fall = f;
    x.err = mErr; x.ev = mEv; x.ev2 = mEv2;
    q.push_back(x);
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk("alarm", int'(alarm), x.alarm);
    chk("rise", int'(rise), x.rise);
    chk("fall", int'(fall), x.fall);
    chk("flag_err", int'(ferr), x.err);
    chk("event_cnt", int'(ev), x.ev);
    chk("event_cnt2", int'(ev2), x.ev2);
    chk("alarm2", int'(alarm2), x.alarm);
    chk("rise_fall_excl", int'(rise & fall), 0);
  endtask

  task automatic up(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0);
  endtask

  task automatic dn(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 1, 0);
  endtask

  task automatic eq(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 1, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, 1, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 0; agtb = 0; aeqb = 0; altb = 0; clr = 0;
    #12;
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_ev", int'(ev), 0);
    chk("rst_err", int'(ferr), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 4 ABOVE raise the alarm on the 4th edge
    up(4);
    dn(4);
    // interrupted arming
    up(3); dn(1); up(4);
    // disarm with equal band and invalid cycles mixed in
    dn(1); idle(1); dn(1);
    eq(1); idle(1); eq(2); idle(1); eq(2);
    dn(1); idle(1); dn(1);
    // disarm aborted by ABOVE
    up(4); dn(3); up(1); idle(2); dn(4);
    // illegal flag sets
    up(2);
    step(1, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    up(2);
    step(0, 0, 0, 0, 1);
    step(1, 1, 1, 1, 1);
    step(1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1);
    // saturation of the narrow counter
    for (int k = 0; k < 5; k++) begin up(4); dn(4); end
    // clear coinciding with a rise
    up(3);
    step(1, 1, 0, 0, 1);
    dn(4);
    up(4); dn(4);
    step(1, 0, 0, 0, 0);
    // asynchronous reset mid-arming
    up(2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_alarm", int'(alarm), 0);
    chk("arst_ev", int'(ev), 0);
    chk("arst_ev2", int'(ev2), 0);
    chk("arst_err", int'(ferr), 0);
    chk("arst_rise", int'(rise), 0);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    up(3); idle(1); up(1); dn(4);
    // random tail
    for (int i = 0; i < 400; i++) begin
      int r;
      logic v, c;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 9);
      if (r < 4) step(v, 1, 0, 0, c);
      else if (r < 7) step(v, 0, 0, 1, c);
      else if (r == 7) step(v, 0, 1, 0, c);
      else if (r == 8) step(v, 0, 0, 0, c);
      else step(v, 1, 1, 0, c);
    end
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/mag_alarm_fsm.md
Name: mag_alarm_fsm

Overview:
Downstream consumer of the 16-bit magnitude comparator flags (sample A versus threshold B).
Debounces the comparator verdicts over consecutive valid samples and drives a hysteretic alarm.
Produces one-cycle rise/fall event pulses and a saturating alarm-event counter.
Flags illegal (non-one-hot) comparator flag combinations with a sticky error.

Parameters:
DEBOUNCE, 4, consecutive qualifying samples needed to change alarm state; legal range 2..255
CNT_W, 8, width of event_cnt

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
valid  input  1  comparator flags below are meaningful this cycle
agtb  input  1  comparator A>B flag
aeqb  input  1  comparator A==B flag
altb  input  1  comparator A<B flag
clr  input  1  synchronous clear of event_cnt and flag_err
alarm  output  1  debounced alarm level
alarm_rise  output  1  one-cycle pulse when alarm goes 0->1
alarm_fall  output  1  one-cycle pulse when alarm goes 1->0
event_cnt  output  CNT_W  number of alarm rises, saturating
flag_err  output  1  sticky: a valid cycle carried a non-one-hot flag set

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, debounce counter=0, alarm=0, alarm_rise=0, alarm_fall=0, event_cnt=0, flag_err=0. Reset mid-debounce discards any partial count.
- Sample classification, only when valid=1 and exactly one flag is set:
  - ABOVE = agtb
  - BELOW = altb
  - EQUAL = aeqb
- Illegal flags: valid=1 with zero or multiple flags set sets flag_err on the next edge. The sample is ignored: state and counter hold.
- valid=0: flags ignored; state and counter hold.
- EQUAL is the hysteresis band: state and counter hold.
- States and transitions (all outputs registered; the change is visible after the edge that samples the qualifying input):
  - IDLE (alarm=0):
    - ABOVE -> ARMING, cnt=1
    - otherwise hold
  - ARMING (alarm=0):
    - ABOVE with cnt+1<DEBOUNCE -> cnt++
    - ABOVE with cnt+1==DEBOUNCE -> ACTIVE, cnt=0, alarm=1, alarm_rise=1, event_cnt++
    - BELOW -> IDLE, cnt=0
  - ACTIVE (alarm=1):
    - BELOW -> DISARMING, cnt=1
    - otherwise hold
  - DISARMING (alarm=1):
    - BELOW with cnt+1<DEBOUNCE -> cnt++
    - BELOW with cnt+1==DEBOUNCE -> IDLE, cnt=0, alarm=0, alarm_fall=1
    - ABOVE -> ACTIVE, cnt=0
- Pulse timing: alarm_rise and alarm_fall are high for exactly one cycle, on the same cycle alarm first shows its new value. They are never high together.
- event_cnt saturates at all-ones; further rises still pulse alarm_rise but do not wrap the counter.
- clr=1: event_cnt=0 and flag_err=0 on the next edge; FSM unaffected.
  - clr coinciding with a rise: event_cnt=0 (clr wins); alarm_rise still pulses.
  - clr coinciding with an illegal flag set: flag_err=0 (clr wins).
- Debounce counter width: ceil(log2(DEBOUNCE+1)), minimum 2 bits.
- Alarm latency from first ABOVE sample (back-to-back valid, DEBOUNCE=4): 4 edges.

Test Plan:
- Reset, then 4 consecutive valid agtb=1 -> alarm=1 after the 4th edge, alarm_rise pulses 1 cycle, event_cnt=1.
- From IDLE: 3 ABOVE, 1 BELOW, 4 ABOVE -> no alarm after the first 3; alarm=1 only after the final 4th ABOVE; event_cnt=1.
- In ACTIVE: 2 BELOW, 5 EQUAL, 2 BELOW with valid toggling -> alarm_fall after the 4th BELOW; alarm stays 1 through the EQUAL/invalid cycles.
- In DISARMING: 3 BELOW, then 1 ABOVE -> back to ACTIVE, alarm never drops; then 4 BELOW -> alarm_fall.
- valid=1, agtb=1, altb=1 -> flag_err=1, state/counter unchanged. Then clr=1 -> flag_err=0, event_cnt=0.
- CNT_W=2: 5 alarm cycles -> event_cnt sticks at 3. rst_n low mid-ARMING -> all outputs 0 immediately, no clock required.
